// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU front-end: debounced buttons load A, B and the opcode from the
// switches in order, then a registered execute stage presents result and flags.
module alu_seq_ctrl #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OPCODE       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_DATA-1:0] i_switch,
    input  logic [3:0]         i_btn,
    output logic [NB_DATA-1:0] o_result,
    output logic [3:0]         o_flags,
    output logic               o_valid,
    output logic               o_err,
    output logic [2:0]         o_state
);

    localparam int unsigned MSB   = NB_DATA - 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Decoded on the low six opcode bits.
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_A    = 3'd0,
        ST_B    = 3'd1,
        ST_OP   = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_q;
    logic [NB_DATA-1:0]   a_q;
    logic [NB_DATA-1:0]   b_q;
    logic [NB_OPCODE-1:0] op_q;

    logic [3:0]           sync_meta;
    logic [3:0]           sync_lvl;
    logic [3:0]           btn_p;
    logic [CNT_W-1:0]     cnt [4];

    logic [5:0]           op_low;
    logic [NB_DATA:0]     sum_ext;
    logic [NB_DATA:0]     diff_ext;
    logic [NB_DATA-1:0]   alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_err;
    logic [3:0]           alu_flags;

    // Button synchronisers and saturating debounce counters; one pulse per press.
    // Runs regardless of i_enable so a press seen while disabled is simply lost.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
            btn_p     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_meta <= i_btn;
            sync_lvl  <= sync_meta;
            for (int i = 0; i < 4; i++) begin
                if (!sync_lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                // Pulse lines up with the cycle the counter holds CNT_MAX.
                btn_p[i] <= sync_lvl[i] && (cnt[i] == CNT_LAST);
            end
        end
    end

    // ALU datapath on the loaded operands; consumed by the execute state.
    always_comb begin
        op_low   = 6'(op_q);
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        diff_ext = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_err  = 1'b0;
        case (op_low)
            OP_ADD: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[NB_DATA];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = diff_ext[NB_DATA];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            // Shift amounts >= NB_DATA fill with sign / zero by language rules.
            OP_SRA: alu_res = $signed(a_q) >>> b_q;
            OP_SRL: alu_res = a_q >> b_q;
            default: alu_err = 1'b1;
        endcase
        alu_flags = alu_err ? 4'b0000 : {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end

    // Load/execute sequencer with registered result, flags, valid and error.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            o_result <= '0;
            o_flags  <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else if (i_enable) begin
            case (state_q)
                ST_A: begin
                    if (btn_p[0]) begin
                        a_q     <= i_switch;
                        state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (btn_p[1]) begin
                        b_q     <= i_switch;
                        state_q <= ST_OP;
                    end else if (btn_p[3]) begin
                        state_q <= ST_A;
                    end
                end
                ST_OP: begin
                    if (btn_p[2]) begin
                        op_q    <= i_switch[NB_OPCODE-1:0];
                        state_q <= ST_EXEC;
                    end else if (btn_p[3]) begin
                        state_q <= ST_A;
                    end
                end
                ST_EXEC: begin
                    o_result <= alu_res;
                    o_flags  <= alu_flags;
                    o_err    <= alu_err;
                    o_valid  <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (btn_p[2]) begin
                        op_q    <= i_switch[NB_OPCODE-1:0];
                        o_valid <= 1'b0;
                        state_q <= ST_EXEC;
                    end else if (btn_p[3]) begin
                        o_valid <= 1'b0;
                        state_q <= ST_A;
                    end
                end
                default: state_q <= ST_A;
            endcase
        end
    end

    assign o_state = state_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Parametrised successor to the board-level ALU top. It synchronises and debounces four push-buttons and walks a state machine that loads operand A, operand B and the opcode from the switches in a fixed order. It then computes the result in a registered execute stage and presents the result with N/Z/C/V flags and a valid indicator. It sits directly between the board switches/buttons and the LED outputs, and contains its own ALU datapath.

Parameters:
NB_DATA, 8, operand and result width (≥4)
NB_OPCODE, 6, opcode width (≤ NB_DATA)
DEBOUNCE_CYCLES, 1000000, consecutive stable-high cycles required to accept a press (≥2; bench uses 4)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  FSM advance enable; when low, state and registers hold
i_switch  in  NB_DATA  data/opcode source
i_btn  in  4  raw buttons: [0] load A, [1] load B, [2] load opcode, [3] restart
o_result  out  NB_DATA  registered ALU result
o_flags  out  4  {N,Z,C,V}, registered with o_result
o_valid  out  1  high while o_result/o_flags reflect the current A/B/opcode
o_err  out  1  high while the last executed opcode is unsupported
o_state  out  3  current FSM state encoding, for LEDs

Behaviour:
- Reset (i_reset=0, async): A, B, opcode, o_result, o_flags, o_valid, o_err = 0; state = ST_A (3'd0); synchronisers and debounce counters cleared.
- Per button: 2-flop synchroniser, then counter. Counter increments while the sync'd level is 1, saturating at DEBOUNCE_CYCLES; it clears on 0. A one-cycle pulse btn_p[i] fires on the cycle the counter reaches DEBOUNCE_CYCLES. There is exactly one pulse per press, with no repeat while held. The pulse is lost if i_enable=0 on that cycle.
- States: ST_A=0, ST_B=1, ST_OP=2, ST_EXEC=3, ST_DONE=4; other encodings go to ST_A.
- ST_A: btn_p[0] → A<=i_switch, go ST_B.
- ST_B: btn_p[1] → B<=i_switch, go ST_OP.
- ST_OP: btn_p[2] → opcode<=i_switch[NB_OPCODE-1:0], go ST_EXEC.
- ST_EXEC: unconditional, one cycle. Register result, flags and err, then go ST_DONE.
- ST_DONE: o_valid=1.
  - btn_p[2] → reload opcode, o_valid<=0, go ST_EXEC.
  - btn_p[3] → o_valid<=0, go ST_A. o_result and o_flags hold their last values.
- Pulses not listed for the current state are ignored. With several pulses in the same cycle, only the one listed for the current state acts.
- btn_p[3] in ST_A/ST_B/ST_OP → go ST_A; A, B and opcode are kept.
- Latency: btn_p[2] in cycle t → ST_EXEC in t+1 → o_valid=1 and outputs updated from t+2.
- Opcodes (low 6 bits):
  - ADD 100000: carry out of NB_DATA+1-bit sum.
  - SUB 100010: A−B, C = borrow (A<B unsigned).
  - AND 100100, OR 100101, XOR 100110, NOR 100111: C=V=0.
  - SRA 000011: A arithmetic-shift-right by unsigned B.
  - SRL 000010: A logic-shift-right by unsigned B. If B≥NB_DATA, SRL gives 0 and SRA gives all copies of A[MSB]. Shifts set C=V=0.
- V: signed overflow for ADD/SUB only. N = result MSB. Z = (result==0).
- Unsupported opcode: result 0, flags 0000, o_err=1. Otherwise o_err=0.
- All arithmetic is modulo 2^NB_DATA.
- Reset mid-operation from any state returns to ST_A with all outputs 0 asynchronously.

Test Plan (NB_DATA=8, NB_OPCODE=6, DEBOUNCE_CYCLES=4):
1. Load A=0x7F, B=0x01, op=0x20 → o_result=0x80, flags N=1 Z=0 C=0 V=1, o_valid rises 2 cycles after the op pulse, o_state=4.
2. A=0x05, B=0x05, op=0x22 (SUB) → 0x00, Z=1 C=0 V=0. Then in ST_DONE reload op=0x27 (NOR) → o_valid drops 1 cycle, then 0xFA with N=1.
3. A=0x90, B=0x02, op=0x03 → 0xE4. Reload op=0x02 → 0x24. Set B=0x09 via restart and reload: SRA → 0xFF, SRL → 0x00.
4. Debounce: btn[0] high 3 cycles → no load, state stays 0. High 20 cycles → exactly one load, state 1. Bounce pattern 1,1,0,1,1,1,1 → a single pulse on the final run.
5. Out-of-order btn[2] and btn[1] in ST_A → ignored. Op=0x3F → o_result=0x00, o_err=1, flags 0000. Restart then valid op → o_err=0.
6. Assert i_reset=0 asynchronously mid-cycle in ST_B and in ST_DONE → outputs 0 immediately, o_state=0. i_enable=0 during a press → no transition, and no delayed action after re-enable.
